// File: rtl/hdlc_tx_framer_if.sv
// hdlc_tx_framer_if: payload handshake, control and serial line between the Tx buffer side and the HDLC framer
interface hdlc_tx_framer_if;
  logic Tx_Start;
  logic [7:0] Tx_Data;
  logic Tx_ByteValid;
  logic Tx_LastByte;
  logic Tx_AbortFrame;
  logic Tx_ByteReq;
  logic Tx;
  logic Tx_ValidFrame;
  logic Tx_Done;
  logic Tx_AbortedTrans;
  modport master(
    output Tx_Start, Tx_Data, Tx_ByteValid, Tx_LastByte, Tx_AbortFrame,
    input Tx_ByteReq, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );
  modport slave(
    input Tx_Start, Tx_Data, Tx_ByteValid, Tx_LastByte, Tx_AbortFrame,
    output Tx_ByteReq, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );
endinterface

// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: bit-serial HDLC Tx framer with flags, zero insertion and abort; define HDLC_TX_FCS_EN to append a CRC-16 FCS
module hdlc_tx_framer #(
  parameter int MAX_BYTES = 126,
  parameter logic [7:0] FLAG = 8'b0111_1110
) (
  input logic Clk,
  input logic Rst,
  hdlc_tx_framer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
    START_FLAG,
    DATA,
    END_FLAG,
`ifdef HDLC_TX_FCS_EN
    FCS,
`endif
    ABORT
  } state_t;
  state_t state;
  logic [2:0] bitCnt, shCnt, ones;
  logic [7:0] shReg, holdReg, byteCnt;
  logic shLast, holdLast, holdFull, lastAcc;
`ifdef HDLC_TX_FCS_EN
  logic [15:0] crc, fcsReg;
  logic [3:0] fcsCnt;
  logic [15:0] crcNext;
`endif
  logic accept, stuff, dataBit, inFrame, abortNow;
  assign bus.Tx_ByteReq = (state == START_FLAG || state == DATA) && !holdFull && !lastAcc;
  assign accept = bus.Tx_ByteReq && bus.Tx_ByteValid;
  assign stuff = ones == 3'd5;
  // an empty shifter takes its next bit straight from the holding register so bytes leave back to back
  assign dataBit = shCnt == 3'd0 ? holdReg[0] : shReg[0];
  assign inFrame = state == START_FLAG || state == DATA
`ifdef HDLC_TX_FCS_EN
    || state == FCS
`endif
    ;
  assign abortNow = (inFrame && (bus.Tx_AbortFrame || (accept && byteCnt == 8'(MAX_BYTES))))
    || (state == DATA && !stuff && shCnt == 3'd0 && !holdFull && !shLast);
`ifdef HDLC_TX_FCS_EN
  assign crcNext = {1'b0, crc[15:1]} ^ ((crc[0] ^ dataBit) ? 16'hA001 : 16'h0000);
`endif
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      bus.Tx <= 1'b1;
      bus.Tx_ValidFrame <= 1'b0;
      bus.Tx_Done <= 1'b0;
      bus.Tx_AbortedTrans <= 1'b0;
      holdFull <= 1'b0;
      lastAcc <= 1'b0;
      ones <= '0;
      byteCnt <= '0;
      bitCnt <= '0;
      shCnt <= '0;
      shLast <= 1'b0;
    end else begin
      bus.Tx_Done <= 1'b0;
      bus.Tx_AbortedTrans <= 1'b0;
      if (accept) begin
        holdReg <= bus.Tx_Data;
        holdLast <= bus.Tx_LastByte;
        holdFull <= 1'b1;
        lastAcc <= bus.Tx_LastByte;
        byteCnt <= byteCnt == 8'hFF ? byteCnt : byteCnt + 8'd1;
      end
      if (abortNow) begin
        state <= ABORT;
        bus.Tx <= 1'b0;
        bitCnt <= 3'd1;
        ones <= '0;
        holdFull <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bus.Tx <= 1'b1;
            if (bus.Tx_Start) begin
              state <= START_FLAG;
              bus.Tx <= FLAG[0];
              bus.Tx_ValidFrame <= 1'b1;
              bitCnt <= 3'd1;
              byteCnt <= '0;
              lastAcc <= 1'b0;
              holdFull <= 1'b0;
              shCnt <= '0;
              shLast <= 1'b0;
              ones <= '0;
`ifdef HDLC_TX_FCS_EN
              crc <= '0;
`endif
            end
          end
          START_FLAG: begin
            bus.Tx <= FLAG[bitCnt];
            bitCnt <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) state <= DATA;
          end
          DATA: begin
            if (stuff) begin
              bus.Tx <= 1'b0;
              ones <= '0;
            end else if (shCnt != 3'd0 || holdFull) begin
              bus.Tx <= dataBit;
              ones <= dataBit ? ones + 3'd1 : 3'd0;
              shReg <= (shCnt == 3'd0 ? holdReg : shReg) >> 1;
              shCnt <= shCnt == 3'd0 ? 3'd7 : shCnt - 3'd1;
`ifdef HDLC_TX_FCS_EN
              crc <= crcNext;
`endif
              if (shCnt == 3'd0) begin
                shLast <= holdLast;
                holdFull <= 1'b0;
              end
            end else begin
`ifdef HDLC_TX_FCS_EN
              state <= FCS;
              bus.Tx <= crc[0];
              ones <= crc[0] ? ones + 3'd1 : 3'd0;
              fcsReg <= {1'b0, crc[15:1]};
              fcsCnt <= 4'd15;
`else
              state <= END_FLAG;
              bus.Tx <= FLAG[0];
              bitCnt <= 3'd1;
              ones <= '0;
`endif
            end
          end
`ifdef HDLC_TX_FCS_EN
          FCS: begin
            if (stuff) begin
              bus.Tx <= 1'b0;
              ones <= '0;
            end else if (fcsCnt != 4'd0) begin
              bus.Tx <= fcsReg[0];
              ones <= fcsReg[0] ? ones + 3'd1 : 3'd0;
              fcsReg <= fcsReg >> 1;
              fcsCnt <= fcsCnt - 4'd1;
            end else begin
              state <= END_FLAG;
              bus.Tx <= FLAG[0];
              bitCnt <= 3'd1;
              ones <= '0;
            end
          end
`endif
          END_FLAG: begin
            bus.Tx <= bitCnt == 3'd0 ? 1'b1 : FLAG[bitCnt];
            bitCnt <= bitCnt + 3'd1;
            if (bitCnt == 3'd0) begin
              state <= IDLE;
              bus.Tx_Done <= 1'b1;
              bus.Tx_ValidFrame <= 1'b0;
            end
          end
          ABORT: begin
            bus.Tx <= 1'b1;
            bitCnt <= bitCnt + 3'd1;
            if (bitCnt == 3'd0) begin
              state <= IDLE;
              bus.Tx_AbortedTrans <= 1'b1;
              bus.Tx_ValidFrame <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
